// File: rtl/sd_data_xfer_sequencer.sv
// Multi-block SD data transfer sequencer: issues one start pulse per block, clears the
// data master status, spaces blocks with an idle gap, requests CMD12 and aggregates status.
`ifndef INT_DATA_SIZE
`define INT_DATA_SIZE 5
`endif
`ifndef INT_DATA_CC
`define INT_DATA_CC 0
`endif
`ifndef INT_DATA_EI
`define INT_DATA_EI 1
`endif
`ifndef INT_DATA_CTE
`define INT_DATA_CTE 2
`endif
`ifndef INT_DATA_CCRCE
`define INT_DATA_CCRCE 3
`endif
`ifndef INT_DATA_CFE
`define INT_DATA_CFE 4
`endif

module sd_data_xfer_sequencer #(
  parameter int BLKCNT_W   = 16,
  parameter int GAP_CYCLES = 2,
  parameter bit AUTO_STOP  = 1'b1
) (
  input  logic                      sd_clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      dir_i,
  input  logic [BLKCNT_W-1:0]       blk_cnt_i,
  input  logic                      abort_i,
  output logic                      start_tx_o,
  output logic                      start_rx_o,
  input  logic [`INT_DATA_SIZE-1:0] dm_int_status_i,
  output logic                      dm_int_rst_o,
  output logic                      stop_cmd_req_o,
  input  logic                      stop_cmd_ack_i,
  output logic                      busy_o,
  output logic [BLKCNT_W:0]         blocks_done_o,
  output logic [`INT_DATA_SIZE-1:0] int_status_o,
  input  logic                      int_status_rst_i
);
  localparam int IW    = `INT_DATA_SIZE;
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IW-1:0] CC_MASK = IW'(1) << `INT_DATA_CC;
  localparam logic [IW-1:0] EI_MASK = IW'(1) << `INT_DATA_EI;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_CLEAR, S_GAP, S_STOP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [BLKCNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                abort_q, abort_d;
  logic [IW-1:0]       cause_q, cause_d;
  logic [BLKCNT_W:0]   done_q, done_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [IW-1:0]       int_q, int_d;

  // A single-block transfer never needs CMD12, so the stop is skipped when count is 0.
  function automatic state_t finish_state(input logic [BLKCNT_W-1:0] cnt);
    return (AUTO_STOP && (cnt != '0)) ? S_STOP : S_DONE;
  endfunction

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      cause_q <= '0;
      done_q  <= '0;
      gap_q   <= '0;
      int_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      cause_q <= cause_d;
      done_q  <= done_d;
      gap_q   <= gap_d;
      int_q   <= int_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    abort_d = abort_q;
    cause_d = cause_q;
    done_d  = done_q;
    gap_d   = gap_q;
    int_d   = int_q;
    if (int_status_rst_i) int_d = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dir_d   = dir_i;
          cnt_d   = blk_cnt_i;
          done_d  = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
          cause_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (abort_i) abort_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (abort_i) abort_d = 1'b1;
        if (|dm_int_status_i) begin
          if (dm_int_status_i[`INT_DATA_EI]) begin
            cause_d = cause_q | dm_int_status_i;
            err_d   = 1'b1;
          end else if (dm_int_status_i[`INT_DATA_CC]) begin
            done_d = done_q + (BLKCNT_W+1)'(1);
          end
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort_i) abort_d = 1'b1;
        gap_d = '0;
        if (err_q || abort_q || abort_i) begin
          state_d = finish_state(cnt_q);
        end else if (done_q == ({1'b0, cnt_q} + (BLKCNT_W+1)'(1))) begin
          state_d = finish_state(cnt_q);
        end else if (GAP_CYCLES == 0) begin
          state_d = S_START;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // An abort here ends the transfer at once instead of launching another block.
        if (abort_i) begin
          abort_d = 1'b1;
          state_d = finish_state(cnt_q);
        end else if (gap_q == GAP_LAST) begin
          state_d = S_START;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_STOP: begin
        if (stop_cmd_ack_i) state_d = S_DONE;
      end
      S_DONE: begin
        int_d   = (err_q || abort_q) ? (EI_MASK | cause_q) : CC_MASK;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign start_tx_o     = (state_q == S_START) &&  dir_q;
  assign start_rx_o     = (state_q == S_START) && !dir_q;
  assign dm_int_rst_o   = (state_q == S_CLEAR);
  assign stop_cmd_req_o = (state_q == S_STOP);
  assign busy_o         = (state_q != S_IDLE);
  assign blocks_done_o  = done_q;
  assign int_status_o   = int_q;

endmodule

// File: tb/tb_sd_data_xfer_sequencer.sv
// Bench for sd_data_xfer_sequencer: data-master/command-path responder, transaction-level
// expectation model, and one compare process checking outputs every cycle.
module tb_sd_data_xfer_sequencer;
  localparam int BW   = 16;
  localparam int GAP  = 2;
  localparam int AUTO = 1;
  localparam int IW   = 5;
  localparam logic [IW-1:0] CC_M    = 5'b00001;
  localparam logic [IW-1:0] EI_M    = 5'b00010;
  localparam logic [IW-1:0] CCRCE_M = 5'b01000;
  localparam int AB_NONE = 0;
  localparam int AB_GAP  = 1;
  localparam int AB_WAIT = 2;

  logic           sd_clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic           dir_i = 1'b0;
  logic [BW-1:0]  blk_cnt_i = '0;
  logic           abort_i = 1'b0;
  logic           start_tx_o, start_rx_o;
  logic [IW-1:0]  dm_int_status_i = '0;
  logic           dm_int_rst_o;
  logic           stop_cmd_req_o;
  logic           stop_cmd_ack_i = 1'b0;
  logic           busy_o;
  logic [BW:0]    blocks_done_o;
  logic [IW-1:0]  int_status_o;
  logic           int_status_rst_i = 1'b0;

  sd_data_xfer_sequencer #(.BLKCNT_W(BW), .GAP_CYCLES(GAP), .AUTO_STOP(1'b1)) dut (
    .sd_clk(sd_clk), .rst(rst), .start_i(start_i), .dir_i(dir_i), .blk_cnt_i(blk_cnt_i),
    .abort_i(abort_i), .start_tx_o(start_tx_o), .start_rx_o(start_rx_o),
    .dm_int_status_i(dm_int_status_i), .dm_int_rst_o(dm_int_rst_o),
    .stop_cmd_req_o(stop_cmd_req_o), .stop_cmd_ack_i(stop_cmd_ack_i), .busy_o(busy_o),
    .blocks_done_o(blocks_done_o), .int_status_o(int_status_o),
    .int_status_rst_i(int_status_rst_i)
  );

  always #5 sd_clk = ~sd_clk;

  // scenario configuration and model expectations (written by the stimulus process only)
  int            cfg_err_blk = -1;
  logic [IW-1:0] cfg_err_st = '0;
  int            cfg_ab_mode = AB_NONE;
  int            cfg_ab_blk = 0;
  logic          exp_dir = 1'b0;
  int            exp_starts = 0;
  int            exp_bd = 0;
  logic [IW-1:0] exp_int = '0;
  logic          exp_stop = 1'b0;
  logic          lit_on = 1'b0;
  logic [IW-1:0] lit_int = '0;
  int            lit_bd = 0;

  // data master / command path responder
  int r_cd = 0, r_cur = 0, r_blk = 0, r_stop_n = 0;
  logic r_arm = 1'b0;
  always @(negedge sd_clk) begin
    abort_i = 1'b0;
    stop_cmd_ack_i = 1'b0;
    if (rst) begin
      dm_int_status_i = '0;
      r_cd = 0; r_blk = 0; r_stop_n = 0; r_arm = 1'b0;
    end else begin
      if (start_tx_o || start_rx_o) begin
        r_cd = 10; r_cur = r_blk; r_blk++;
      end else if (r_cd > 0) begin
        r_cd--;
        if (cfg_ab_mode == AB_WAIT && r_cur == cfg_ab_blk && r_cd == 5) abort_i = 1'b1;
        if (r_cd == 0) dm_int_status_i = (r_cur == cfg_err_blk) ? cfg_err_st : CC_M;
      end
      if (dm_int_rst_o) begin
        dm_int_status_i = '0;
        if (cfg_ab_mode == AB_GAP && r_cur == cfg_ab_blk) r_arm = 1'b1;
      end else if (r_arm) begin
        abort_i = 1'b1; r_arm = 1'b0;
      end
      if (stop_cmd_req_o) begin
        r_stop_n++;
        if (r_stop_n == 3) stop_cmd_ack_i = 1'b1;
      end else begin
        r_stop_n = 0;
      end
      if (!busy_o) begin r_blk = 0; r_arm = 1'b0; end
    end
  end

  // compare process
  int vec = 0, miscomp = 0;
  int cyc = 0, last_clr = 0, bcnt = 0;
  int n_start = 0, n_tx = 0, n_rx = 0, n_clr = 0;
  logic stop_seen = 1'b0, first = 1'b0, busy_prev = 1'b0, irst_s = 1'b0, ack_s = 1'b0;
  logic [IW-1:0] model_int = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      miscomp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge sd_clk or posedge rst);
      if (rst) begin
        #1;
        chk("rst_start_tx", 32'(start_tx_o), 32'd0);
        chk("rst_start_rx", 32'(start_rx_o), 32'd0);
        chk("rst_dm_int_rst", 32'(dm_int_rst_o), 32'd0);
        chk("rst_stop_req", 32'(stop_cmd_req_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_blocks_done", 32'(blocks_done_o), 32'd0);
        chk("rst_int_status", 32'(int_status_o), 32'd0);
        busy_prev = 1'b0; model_int = '0; bcnt = 0; first = 1'b0;
      end else begin
        irst_s = int_status_rst_i;
        ack_s  = stop_cmd_ack_i;
        @(negedge sd_clk);
        cyc++;
        chk("tx_rx_exclusive", 32'(start_tx_o & start_rx_o), 32'd0);
        if (busy_o && !busy_prev) begin
          n_start = 0; n_tx = 0; n_rx = 0; n_clr = 0; stop_seen = 1'b0; first = 1'b1;
          chk("blocks_done_cleared", 32'(blocks_done_o), 32'd0);
          chk("first_start_pulse", 32'(start_tx_o | start_rx_o), 32'd1);
        end
        if (start_tx_o || start_rx_o) begin
          n_start++;
          if (start_tx_o) n_tx++;
          if (start_rx_o) n_rx++;
          chk("start_dir", 32'(start_tx_o), 32'(exp_dir));
          if (!first) chk("gap_len", 32'(cyc - last_clr), 32'(GAP + 1));
          first = 1'b0;
        end
        if (dm_int_rst_o) begin n_clr++; last_clr = cyc; end
        if (stop_cmd_req_o) stop_seen = 1'b1;
        if (ack_s) begin
          chk("stop_drop_after_ack", 32'(stop_cmd_req_o), 32'd0);
          chk("done_after_ack", 32'(busy_o), 32'd1);
        end
        if (busy_prev && !busy_o) begin
          model_int = exp_int;
          chk("start_count", 32'(n_start), 32'(exp_starts));
          chk("tx_count", 32'(n_tx), exp_dir ? 32'(exp_starts) : 32'd0);
          chk("rx_count", 32'(n_rx), exp_dir ? 32'd0 : 32'(exp_starts));
          chk("clr_count", 32'(n_clr), 32'(exp_starts));
          chk("stop_requested", 32'(stop_seen), 32'(exp_stop));
          chk("blocks_done", 32'(blocks_done_o), 32'(exp_bd));
          if (lit_on) begin
            chk("lit_int_status", 32'(int_status_o), 32'(lit_int));
            chk("lit_blocks_done", 32'(blocks_done_o), 32'(lit_bd));
          end
        end else if (irst_s) begin
          model_int = '0;
        end
        chk("int_status", 32'(int_status_o), 32'(model_int));
        if (busy_o) bcnt++; else bcnt = 0;
        if (bcnt == 2000) begin
          vec++; miscomp++;
          $display("FAIL busy_timeout: busy for %0d cycles, expected under 2000", bcnt);
        end
        busy_prev = busy_o;
      end
    end
  end

  // stimulus
  task automatic run_xfer(input logic d, input int nb, input int eb, input logic [IW-1:0] es,
                          input int am, input int ab, input logic [IW-1:0] li, input int lbd,
                          input logic dclr);
    cfg_err_blk = eb; cfg_err_st = es; cfg_ab_mode = am; cfg_ab_blk = ab;
    exp_dir = d; exp_stop = (AUTO == 1) && (nb > 1);
    if (eb >= 0 && eb < nb) begin
      exp_starts = eb + 1; exp_bd = eb; exp_int = EI_M | es;
    end else if (am != AB_NONE) begin
      exp_starts = ab + 1; exp_bd = ab + 1; exp_int = EI_M;
    end else begin
      exp_starts = nb; exp_bd = nb; exp_int = CC_M;
    end
    lit_on = 1'b1; lit_int = li; lit_bd = lbd;
    @(negedge sd_clk);
    dir_i = d; blk_cnt_i = BW'(nb - 1); start_i = 1'b1;
    @(negedge sd_clk);
    start_i = 1'b0;
    if (dclr) begin
      for (int i = 0; i < 200 && !dm_int_rst_o; i++) @(negedge sd_clk);
      @(negedge sd_clk);
      int_status_rst_i = 1'b1;
      @(negedge sd_clk);
      int_status_rst_i = 1'b0;
      @(negedge sd_clk);
      int_status_rst_i = 1'b1;
      @(negedge sd_clk);
      int_status_rst_i = 1'b0;
    end
    for (int i = 0; i < 3000 && busy_o; i++) @(negedge sd_clk);
    repeat (3) @(negedge sd_clk);
  endtask

  initial begin
    int nst;
    repeat (3) @(negedge sd_clk);
    rst = 1'b0;
    repeat (2) @(negedge sd_clk);
    run_xfer(1'b0, 1, -1, '0, AB_NONE, 0, 5'b00001, 1, 1'b0);
    run_xfer(1'b1, 4, -1, '0, AB_NONE, 0, 5'b00001, 4, 1'b0);
    run_xfer(1'b1, 4, 1, EI_M | CCRCE_M, AB_NONE, 0, 5'b01010, 1, 1'b0);
    run_xfer(1'b0, 3, -1, '0, AB_GAP, 0, 5'b00010, 1, 1'b0);
    run_xfer(1'b1, 4, -1, '0, AB_WAIT, 1, 5'b00010, 2, 1'b0);
    run_xfer(1'b0, 1, -1, '0, AB_WAIT, 0, 5'b00010, 1, 1'b0);

    cfg_err_blk = -1; cfg_ab_mode = AB_NONE; exp_dir = 1'b1; lit_on = 1'b0;
    @(negedge sd_clk);
    dir_i = 1'b1; blk_cnt_i = BW'(3); start_i = 1'b1;
    @(negedge sd_clk);
    start_i = 1'b0;
    nst = 0;
    for (int i = 0; i < 200; i++) begin
      if (start_tx_o || start_rx_o) nst++;
      if (nst == 2) break;
      @(negedge sd_clk);
    end
    repeat (3) @(negedge sd_clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge sd_clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge sd_clk);
    run_xfer(1'b1, 1, -1, '0, AB_NONE, 0, 5'b00001, 1, 1'b0);

    run_xfer(1'b0, 1, -1, '0, AB_NONE, 0, 5'b00001, 1, 1'b1);
    repeat (3) @(negedge sd_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end

endmodule

// File: doc/sd_data_xfer_sequencer.md
Name: sd_data_xfer_sequencer

Overview:
Multi-block transfer scheduler that sits above sd_data_master. It issues one start_tx/start_rx pulse per block, waits for each block's completion status, clears the data master's interrupt status, and inserts a programmable inter-block gap. On the last block, on error, or on abort it requests an automatic stop command (CMD12) from the command path. It then presents a single sticky aggregated data interrupt status to the register file.

Parameters:
BLKCNT_W, 16, width of the block-count field.
GAP_CYCLES, 2, idle sd_clk cycles between a block's status clear and the next start pulse (0 allowed).
AUTO_STOP, 1, 1 = request a stop command after multi-block transfers; 0 = never request.

Ports:
sd_clk  input  1  block clock. One clock only.
rst  input  1  reset, asynchronous, active-high.
start_i  input  1  single-cycle transfer request; ignored while busy_o=1.
dir_i  input  1  1 = write to card (tx path), 0 = read from card (rx path); sampled with start_i.
blk_cnt_i  input  BLKCNT_W  number of blocks minus 1; sampled with start_i.
abort_i  input  1  single-cycle abort request.
start_tx_o  output  1  one-cycle pulse to sd_data_master start_tx_i.
start_rx_o  output  1  one-cycle pulse to sd_data_master start_rx_i.
dm_int_status_i  input  `INT_DATA_SIZE  sd_data_master int_status_o.
dm_int_rst_o  output  1  one-cycle pulse to sd_data_master int_status_rst_i.
stop_cmd_req_o  output  1  level request for a stop command.
stop_cmd_ack_i  input  1  pulse from the command path when the stop command has completed.
busy_o  output  1  transfer in progress.
blocks_done_o  output  BLKCNT_W+1  count of blocks completed with CC and no EI in the current or last transfer.
int_status_o  output  `INT_DATA_SIZE  sticky aggregated status; bit positions are INT_DATA_CC / EI / CTE / CCRCE / CFE.
int_status_rst_i  input  1  clears int_status_o.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state returns to IDLE.
  - All outputs are 0, including blocks_done_o and int_status_o.
  - Latched dir, count, error and abort flags are cleared.
  - sd_data_master is reset by its own rst; the sequencer does not drive it.
- States: IDLE, START, WAIT, CLEAR, GAP, STOP, DONE.
- IDLE, on start_i=1:
  - Latch dir_i and blk_cnt_i.
  - Clear blocks_done_o and the error/abort flags.
  - busy_o=1 from the next cycle; go to START.
- START: assert start_tx_o (dir=1) or start_rx_o (dir=0) for exactly this one cycle, then go to WAIT. start_tx_o and start_rx_o are never high together.
- WAIT: hold until dm_int_status_i != 0.
  - If the EI bit is set: OR dm_int_status_i into an error-cause register and set the error flag.
  - Else, if CC is set: increment blocks_done_o.
  - Go to CLEAR.
- CLEAR: dm_int_rst_o=1 for one cycle. The next state is decided in this priority order:
  - error or abort pending: STOP if AUTO_STOP=1 and the latched count != 0, else DONE.
  - blocks_done_o == latched count + 1: STOP if AUTO_STOP=1 and the latched count != 0, else DONE.
  - otherwise: GAP.
- GAP: count GAP_CYCLES cycles, then go to START. With GAP_CYCLES=0, CLEAR goes directly to START.
- STOP: hold stop_cmd_req_o=1 until stop_cmd_ack_i=1 is sampled. stop_cmd_req_o drops the cycle after the ack; go to DONE.
- DONE, for one cycle:
  - Set int_status_o to (1<<INT_DATA_CC) if there was no error and no abort.
  - Else set int_status_o to (1<<INT_DATA_EI) OR'd with the error-cause register. An abort with no error gives EI alone.
  - busy_o=0 from the next cycle; return to IDLE.
- abort_i handling:
  - In IDLE/DONE: ignored.
  - In START/WAIT/CLEAR: latched as pending. The block in flight is allowed to finish; sd_data_master has no abort and relies on its own timeout.
  - In GAP: latched; the gap is cut short and STOP/DONE is entered next cycle by the CLEAR priority rules.
  - In STOP: no effect.
- Simultaneous events:
  - int_status_rst_i in the same cycle as the DONE set: the set wins.
  - start_i in the DONE cycle: ignored.
  - dm_int_status_i nonzero in any state other than WAIT: ignored.
- blocks_done_o is BLKCNT_W+1 bits wide, so a count of 2^BLKCNT_W blocks does not wrap.
- No internal timeout. Hang protection comes from sd_data_master timeout_i (CTE) and the command path timeout.

Test Plan:
- Single-block read: dir=0, blk_cnt=0, model returns CC after 10 cycles.
  - One start_rx_o pulse, one dm_int_rst_o pulse.
  - No stop_cmd_req_o.
  - int_status_o=1<<CC, blocks_done_o=1.
- Four-block write, GAP_CYCLES=2:
  - Exactly 4 start_tx_o pulses, each 3 cycles after the preceding dm_int_rst_o.
  - stop_cmd_req_o held until ack; int_status_o=CC, blocks_done_o=4.
- CRC error on block 2 of 4 (status EI|CCRCE):
  - No 3rd start pulse; stop requested.
  - int_status_o=EI|CCRCE, blocks_done_o=1.
- abort_i during GAP after block 1 of 3:
  - No further start pulse; stop requested.
  - int_status_o=EI, blocks_done_o=1.
- abort_i during WAIT:
  - The block completes with CC and blocks_done_o increments.
  - Then STOP, then int_status_o=EI.
- rst asserted mid-WAIT of block 2:
  - All outputs 0 immediately, without waiting for an sd_clk edge.
  - A new start_i after reset runs a clean 1-block transfer ending in CC.
- int_status_rst_i in the DONE cycle:
  - int_status_o still shows CC.
  - A pulse one cycle later clears it to 0.
